// File: rtl/hp_manager.sv
//==============================================================================
// Module      : hp_manager
// Description : Two-player hit-point tracker. Each player runs an independent
//               ALIVE / INVULN / DEAD state machine driven by rising edges of
//               its hit input. After a non-lethal hit the player gets a timed
//               invulnerability window. A one-cycle ko pulse is produced when
//               either player first drops to zero HP.
//               Optional macro HP_REGEN_EN enables slow HP regeneration for
//               living players below full health.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module hp_manager #(
    parameter int HP_MAX       = 3,
    parameter int COOLDOWN     = 50_000_000,
    parameter int REGEN_CYCLES = 500_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] game_state,
    input  logic       game_pause,
    input  logic       hit1,
    input  logic       hit2,
    output logic [2:0] hp1,
    output logic [2:0] hp2,
    output logic       inv1,
    output logic       inv2,
    output logic       dead1,
    output logic       dead2,
    output logic       ko
);

    // The shared counter serves both the cooldown and (optionally) the regen
    // timer, so it is sized for the larger of the two.
    localparam int c_MAX_CNT = (COOLDOWN > REGEN_CYCLES) ? COOLDOWN : REGEN_CYCLES;
    localparam int c_CNT_W   = $clog2(c_MAX_CNT + 1);

    localparam logic [2:0]         c_HP_MAX    = 3'(HP_MAX);
    localparam logic [c_CNT_W-1:0] c_COOL_LOAD = c_CNT_W'(COOLDOWN - 1);
`ifdef HP_REGEN_EN
    localparam logic [c_CNT_W-1:0] c_REGEN_LAST = c_CNT_W'(REGEN_CYCLES - 1);
`endif

    localparam logic [1:0] c_ST_ALIVE  = 2'd0;
    localparam logic [1:0] c_ST_INVULN = 2'd1;
    localparam logic [1:0] c_ST_DEAD   = 2'd2;

    // Play advances only while playing and not paused; lobby reloads
    // everything; end/reserved simply hold.
    logic w_active;
    logic w_lobby;
    assign w_active = (game_state == 2'b01) && !game_pause;
    assign w_lobby  = (game_state == 2'b00);

    logic [1:0]      w_hit;
    logic [1:0]      w_die;
    logic [1:0][2:0] w_hp;
    logic [1:0][1:0] w_state;

    assign w_hit = {hit2, hit1};

    for (genvar gi = 0; gi < 2; gi++) begin : g_player
        logic               r_hit_q;
        logic [2:0]         r_hp;
        logic [1:0]         r_state;
        logic [c_CNT_W-1:0] r_cnt;
        logic               w_evt;

        // Hit-level history; tracks every cycle so a level held across a
        // pause or lobby is not mistaken for a fresh strike later.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_hit_q <= 1'b0;
            end else begin
                r_hit_q <= w_hit[gi];
            end
        end

        assign w_evt      = w_hit[gi] & ~r_hit_q;
        assign w_die[gi]  = w_active && (r_state == c_ST_ALIVE) && w_evt && (r_hp <= 3'd1);

        // Per-player HP / state / timer update.
        always_ff @(posedge clk) begin
            if (rst || w_lobby) begin
                r_hp    <= c_HP_MAX;
                r_state <= c_ST_ALIVE;
                r_cnt   <= '0;
            end else if (w_active) begin
                case (r_state)
                    c_ST_ALIVE: begin
                        if (w_evt) begin
                            if (r_hp <= 3'd1) begin
                                r_hp    <= 3'd0;
                                r_state <= c_ST_DEAD;
                                r_cnt   <= '0;
                            end else begin
                                r_hp    <= r_hp - 3'd1;
                                r_state <= c_ST_INVULN;
                                r_cnt   <= c_COOL_LOAD;
                            end
                        end else begin
`ifdef HP_REGEN_EN
                            // Regen only while wounded; full health keeps
                            // the timer parked at zero.
                            if ((r_hp != 3'd0) && (r_hp < c_HP_MAX)) begin
                                if (r_cnt == c_REGEN_LAST) begin
                                    r_hp  <= r_hp + 3'd1;
                                    r_cnt <= '0;
                                end else begin
                                    r_cnt <= r_cnt + 1'b1;
                                end
                            end else begin
                                r_cnt <= '0;
                            end
`else
                            r_cnt <= '0;
`endif
                        end
                    end
                    c_ST_INVULN: begin
                        // Counter was loaded with COOLDOWN-1, so the exit
                        // edge lands after exactly COOLDOWN active cycles.
                        if (r_cnt == '0) begin
                            r_state <= c_ST_ALIVE;
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                    c_ST_DEAD: begin
                        r_hp  <= 3'd0;
                        r_cnt <= '0;
                    end
                    default: begin
                        r_state <= c_ST_ALIVE;
                        r_cnt   <= '0;
                    end
                endcase
            end
        end

        assign w_hp[gi]    = r_hp;
        assign w_state[gi] = r_state;
    end

    // Single knockout pulse even when both players fall on the same edge.
    logic r_ko;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ko <= 1'b0;
        end else begin
            r_ko <= |w_die;
        end
    end

    assign hp1   = w_hp[0];
    assign hp2   = w_hp[1];
    assign inv1  = (w_state[0] == c_ST_INVULN);
    assign inv2  = (w_state[1] == c_ST_INVULN);
    assign dead1 = (w_state[0] == c_ST_DEAD);
    assign dead2 = (w_state[1] == c_ST_DEAD);
    assign ko    = r_ko;

endmodule

`default_nettype wire

// File: tb/tb_hp_manager.sv
//==============================================================================
// Module      : tb_hp_manager
// Description : Directed self-checking bench for hp_manager with
//               HP_MAX=3, COOLDOWN=4, REGEN_CYCLES=8.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_hp_manager;

    logic       clk;
    logic       rst;
    logic [1:0] game_state;
    logic       game_pause;
    logic       hit1;
    logic       hit2;
    logic [2:0] hp1;
    logic [2:0] hp2;
    logic       inv1;
    logic       inv2;
    logic       dead1;
    logic       dead2;
    logic       ko;

    int n_tests = 0;
    int n_fail  = 0;

    hp_manager #(
        .HP_MAX      (3),
        .COOLDOWN    (4),
        .REGEN_CYCLES(8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .game_state(game_state),
        .game_pause(game_pause),
        .hit1      (hit1),
        .hit2      (hit2),
        .hp1       (hp1),
        .hp2       (hp2),
        .inv1      (inv1),
        .inv2      (inv2),
        .dead1     (dead1),
        .dead2     (dead2),
        .ko        (ko)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n clock edges, landing 1 time unit after the last edge.
    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Return both players to full health and enter play.
    task automatic reload();
        hit1 = 1'b0; hit2 = 1'b0; game_pause = 1'b0;
        game_state = 2'b00; step(1);
        game_state = 2'b01; step(1);
    endtask

    task automatic test_reset();
        rst = 1'b1; game_state = 2'b00; game_pause = 1'b0; hit1 = 1'b0; hit2 = 1'b0;
        step(2);
        n_tests++; if (hp1 !== 3'd3) begin n_fail++; $display("FAIL reset_hp1: got %0d expected 3", hp1); end
        n_tests++; if (hp2 !== 3'd3) begin n_fail++; $display("FAIL reset_hp2: got %0d expected 3", hp2); end
        n_tests++; if ({inv1, inv2, dead1, dead2, ko} !== 5'b0) begin n_fail++; $display("FAIL reset_flags: got %b expected 00000", {inv1, inv2, dead1, dead2, ko}); end
        rst = 1'b0;
    endtask

    task automatic test_single_hit();
        game_state = 2'b01; step(1);
        hit1 = 1'b1; step(1);
        hit1 = 1'b0;
        n_tests++; if (hp1 !== 3'd2) begin n_fail++; $display("FAIL hit_hp1: got %0d expected 2", hp1); end
        n_tests++; if (inv1 !== 1'b1) begin n_fail++; $display("FAIL hit_inv1_on: got %b expected 1", inv1); end
        step(3);
        n_tests++; if (inv1 !== 1'b1) begin n_fail++; $display("FAIL hit_inv1_4th: got %b expected 1", inv1); end
        step(1);
        n_tests++; if (inv1 !== 1'b0) begin n_fail++; $display("FAIL hit_inv1_off: got %b expected 0", inv1); end
        n_tests++; if (hp2 !== 3'd3) begin n_fail++; $display("FAIL hit_hp2: got %0d expected 3", hp2); end
    endtask

    task automatic test_invuln_ignore();
        reload();
        hit1 = 1'b1; step(1);
        hit1 = 1'b0; step(1);
        hit1 = 1'b1; step(1);
        hit1 = 1'b0;
        n_tests++; if (hp1 !== 3'd2) begin n_fail++; $display("FAIL inv_ignore_hp1: got %0d expected 2", hp1); end
        n_tests++; if (inv1 !== 1'b1) begin n_fail++; $display("FAIL inv_ignore_inv1: got %b expected 1", inv1); end
        step(2);
        n_tests++; if (inv1 !== 1'b0) begin n_fail++; $display("FAIL inv_ignore_end: got %b expected 0", inv1); end
        n_tests++; if (hp1 !== 3'd2) begin n_fail++; $display("FAIL inv_ignore_hp1_end: got %0d expected 2", hp1); end
    endtask

    task automatic test_to_death();
        logic [2:0] exp_hp;
        reload();
        for (int i = 1; i <= 3; i++) begin
            exp_hp = 3'(3 - i);
            hit2 = 1'b1; step(1);
            hit2 = 1'b0;
            n_tests++; if (hp2 !== exp_hp) begin n_fail++; $display("FAIL death_hp2_%0d: got %0d expected %0d", i, hp2, exp_hp); end
            n_tests++; if (ko !== (i == 3)) begin n_fail++; $display("FAIL death_ko_%0d: got %b expected %b", i, ko, (i == 3)); end
            n_tests++; if (inv2 !== (i != 3)) begin n_fail++; $display("FAIL death_inv2_%0d: got %b expected %b", i, inv2, (i != 3)); end
            if (i != 3) step(4);
        end
        n_tests++; if (dead2 !== 1'b1) begin n_fail++; $display("FAIL death_dead2: got %b expected 1", dead2); end
        step(1);
        n_tests++; if (ko !== 1'b0) begin n_fail++; $display("FAIL death_ko_clear: got %b expected 0", ko); end
        hit2 = 1'b1; step(1);
        hit2 = 1'b0;
        n_tests++; if ({hp2, dead2, ko} !== {3'd0, 1'b1, 1'b0}) begin n_fail++; $display("FAIL death_extra_hit: got hp=%0d dead=%b ko=%b expected hp=0 dead=1 ko=0", hp2, dead2, ko); end
        n_tests++; if (hp1 !== 3'd3) begin n_fail++; $display("FAIL death_hp1: got %0d expected 3", hp1); end
    endtask

    task automatic test_double_ko();
        reload();
        for (int i = 0; i < 2; i++) begin
            hit1 = 1'b1; hit2 = 1'b1; step(1);
            hit1 = 1'b0; hit2 = 1'b0; step(4);
        end
        n_tests++; if ({hp1, hp2} !== {3'd1, 3'd1}) begin n_fail++; $display("FAIL dko_pre: got %0d/%0d expected 1/1", hp1, hp2); end
        hit1 = 1'b1; hit2 = 1'b1; step(1);
        hit1 = 1'b0; hit2 = 1'b0;
        n_tests++; if ({hp1, hp2} !== {3'd0, 3'd0}) begin n_fail++; $display("FAIL dko_hp: got %0d/%0d expected 0/0", hp1, hp2); end
        n_tests++; if ({dead1, dead2, ko} !== 3'b111) begin n_fail++; $display("FAIL dko_flags: got %b expected 111", {dead1, dead2, ko}); end
        step(1);
        n_tests++; if (ko !== 1'b0) begin n_fail++; $display("FAIL dko_ko_once: got %b expected 0", ko); end
    endtask

    task automatic test_lobby();
        game_state = 2'b00; step(1);
        n_tests++; if ({hp1, hp2} !== {3'd3, 3'd3}) begin n_fail++; $display("FAIL lobby_hp: got %0d/%0d expected 3/3", hp1, hp2); end
        n_tests++; if ({inv1, inv2, dead1, dead2} !== 4'b0) begin n_fail++; $display("FAIL lobby_flags: got %b expected 0000", {inv1, inv2, dead1, dead2}); end
        game_state = 2'b01; step(1);
    endtask

    task automatic test_hold_end();
        reload();
        game_state = 2'b10;
        hit2 = 1'b1; step(1);
        hit2 = 1'b0; step(1);
        game_state = 2'b11;
        hit2 = 1'b1; step(1);
        n_tests++; if (hp2 !== 3'd3) begin n_fail++; $display("FAIL hold_end_hp2: got %0d expected 3", hp2); end
        game_state = 2'b01; step(2);
        hit2 = 1'b0;
        n_tests++; if (hp2 !== 3'd3) begin n_fail++; $display("FAIL hold_resume_hp2: got %0d expected 3", hp2); end
    endtask

    task automatic test_pause();
        reload();
        hit1 = 1'b1; step(1);
        hit1 = 1'b0; step(1);
        game_pause = 1'b1;
        for (int i = 0; i < 10; i++) begin
            hit1 = (i % 2 == 1);
            step(1);
        end
        n_tests++; if ({hp1, inv1} !== {3'd2, 1'b1}) begin n_fail++; $display("FAIL pause_frozen: got hp=%0d inv=%b expected hp=2 inv=1", hp1, inv1); end
        game_pause = 1'b0;
        step(2);
        n_tests++; if (inv1 !== 1'b1) begin n_fail++; $display("FAIL pause_remaining: got %b expected 1", inv1); end
        step(1);
        n_tests++; if (inv1 !== 1'b0) begin n_fail++; $display("FAIL pause_resume_end: got %b expected 0", inv1); end
        step(2);
        n_tests++; if (hp1 !== 3'd2) begin n_fail++; $display("FAIL pause_held_level: got %0d expected 2", hp1); end
        hit1 = 1'b0; step(1);
    endtask

    task automatic test_reset_override();
        reload();
        hit1 = 1'b1; step(1);
        hit1 = 1'b0;
        rst = 1'b1; step(1);
        rst = 1'b0;
        n_tests++; if ({hp1, inv1} !== {3'd3, 1'b0}) begin n_fail++; $display("FAIL rst_override: got hp=%0d inv=%b expected hp=3 inv=0", hp1, inv1); end
        game_state = 2'b01;
        hit1 = 1'b1; rst = 1'b1; step(1);
        rst = 1'b0; step(1);
        hit1 = 1'b0;
        n_tests++; if (hp1 !== 3'd2) begin n_fail++; $display("FAIL rst_first_edge: got %0d expected 2", hp1); end
    endtask

    task automatic test_regen();
        reload();
        hit1 = 1'b1; step(1);
        hit1 = 1'b0; step(4);
`ifdef HP_REGEN_EN
        step(7);
        n_tests++; if (hp1 !== 3'd2) begin n_fail++; $display("FAIL regen_early: got %0d expected 2", hp1); end
        step(1);
        n_tests++; if (hp1 !== 3'd3) begin n_fail++; $display("FAIL regen_step: got %0d expected 3", hp1); end
`else
        step(20);
        n_tests++; if (hp1 !== 3'd2) begin n_fail++; $display("FAIL no_regen: got %0d expected 2", hp1); end
`endif
    endtask

    initial begin
        rst = 1'b1; game_state = 2'b00; game_pause = 1'b0; hit1 = 1'b0; hit2 = 1'b0;
        test_reset();
        test_single_hit();
        test_invuln_ignore();
        test_to_death();
        test_double_ko();
        test_lobby();
        test_hold_end();
        test_pause();
        test_reset_override();
        test_regen();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/hp_manager.md
HP_MANAGER -- requirements
Module: hp_manager

Interface
REQ-001 Parameter HP_MAX, default 3, starting/maximum hit points per player (1..7).
REQ-002 Parameter COOLDOWN, default 50_000_000, invulnerability length in clk cycles after a non-lethal hit (>=1).
REQ-003 Parameter REGEN_CYCLES, default 500_000_000, hit-free cycles before +1 HP (used only under HP_REGEN_EN).
REQ-004 clk  input  1  system clock; single clock domain, all state updates on posedge clk.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 game_state  input  2  00 lobby, 01 playing, 10 end, 11 reserved.
REQ-007 game_pause  input  1  high = play frozen.
REQ-008 hit1 / hit2  input  1 each  level strike indication on player 1 / player 2, synchronous to clk.
REQ-009 hp1 / hp2  output  3 each  registered hit points of player 1 / player 2.
REQ-010 inv1 / inv2  output  1 each  high while the player is invulnerable.
REQ-011 dead1 / dead2  output  1 each  high while the player's HP is 0.
REQ-012 ko  output  1  one-cycle pulse on the cycle either player's HP first reaches 0.

Function
REQ-013 Each player SHALL have an independent FSM with states ALIVE, INVULN and DEAD, plus a counter of width clog2(max(COOLDOWN, REGEN_CYCLES)+1).
REQ-014 A hit event SHALL be a rising edge: hitN sampled 1 on this edge and 0 on the previous edge, using a registered copy of hitN.
REQ-015 "Active" SHALL mean game_state==01 and game_pause==0.
REQ-016 When active, a hit event in ALIVE SHALL decrement hp by 1, visible on the outputs after the same clock edge that samples the event.
REQ-017 If the decrement yields 0, the FSM SHALL enter DEAD, assert deadN and pulse ko for exactly one cycle; otherwise it SHALL enter INVULN and load counter = COOLDOWN-1.
REQ-018 In INVULN, the counter SHALL decrement each active cycle; at counter==0 the FSM SHALL return to ALIVE on the next edge, giving exactly COOLDOWN active cycles of invulnerability.
REQ-019 Hit events in INVULN or DEAD SHALL be ignored, with no hp change.
REQ-020 Simultaneous hit events on both players in one cycle SHALL both be applied; ko SHALL pulse once even if both players die.
REQ-021 With game_pause=1 or game_state==10, hp, FSM state and counters SHALL hold, and edges occurring in that window SHALL be discarded.
REQ-022 game_state==00 SHALL force hp=HP_MAX, state ALIVE and counters 0 on every edge.
REQ-023 game_state==11 SHALL behave as 10 (hold).
REQ-024 The hit-edge registers SHALL update every cycle regardless of game_state, so a level held through a pause does not count as a new event when play resumes.
REQ-025 hp SHALL never underflow below 0 or exceed HP_MAX.
REQ-026 Outputs SHALL be combinational decodes of registered state only: invN = (state==INVULN), deadN = (state==DEAD).

Reset
REQ-027 On rst=1 at posedge clk: hp1=hp2=HP_MAX, both FSMs ALIVE, counters 0, hit-edge registers 0, ko=0.
REQ-028 This gives inv=0 and dead=0. rst SHALL override all other inputs, including an in-progress INVULN countdown.
REQ-029 The first rising edge SHALL be detectable on the cycle after reset deasserts.

Configuration
REQ-030 Macro HP_REGEN_EN: when defined, a player in ALIVE with 0<hp<HP_MAX SHALL count active hit-free cycles and gain +1 hp after REGEN_CYCLES of them.
REQ-031 Under HP_REGEN_EN, the regen counter SHALL restart at 0 after each regen step and after any hit.
REQ-032 Under HP_REGEN_EN, DEAD players SHALL NOT regenerate.
REQ-033 With HP_REGEN_EN undefined, no regen logic SHALL be compiled and hp SHALL be non-increasing except via lobby reload or reset.

Verification (COOLDOWN=4, REGEN_CYCLES=8, HP_MAX=3)
REQ-034 Test 1: rst 1 cycle, then game_state=01 and a one-cycle hit1 pulse -> hp1=2 and inv1=1 the next cycle; inv1 low after exactly 4 cycles; hp2 stays 3.
REQ-035 Test 2: second hit1 pulse 2 cycles into INVULN -> ignored, hp1 stays 2.
REQ-036 Test 3: three spaced hit2 pulses, each after cooldown -> hp2 goes 3,2,1,0; dead2=1; ko high exactly one cycle; further hit2 has no effect.
REQ-037 Test 4: hit1 and hit2 rising on the same cycle with both at hp=1 -> both hp=0, both dead, single ko pulse.
REQ-038 Test 5: game_pause=1 mid-INVULN for 10 cycles with hit1 toggling -> hp and counter frozen; countdown resumes with the remaining count after unpause; no hp change from the toggles.
REQ-039 Test 6: game_state=00 after dead1 -> hp1=hp2=3 next cycle, all inv/dead 0. Under HP_REGEN_EN: hp1=2 left idle 8 active cycles after cooldown -> hp1=3.
